// File: rtl/divider_inverse.sv
// Iterative shift-and-add reconstructor: dividend = quotient * divisor + remainder.
// One multiplier bit per cycle, fixed latency of WIDTH+1 cycles, single-cycle valid pulse.
`timescale 1ns/1ps

module divider_inverse #(
    parameter int unsigned WIDTH = 9
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     quotient_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic [WIDTH-1:0]     remainder_in,
    input  logic                 data_valid_in,
    output logic [WIDTH-1:0]     dividend_out,
    output logic [2*WIDTH-1:0]   product_full_out,
    output logic                 overflow_out,
    output logic                 error_out,
    output logic                 busy_out,
    output logic                 data_valid_out
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CntW-1:0]      count;
    logic                 err_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= StIdle;
            acc              <= '0;
            mcand            <= '0;
            mplier           <= '0;
            count            <= '0;
            err_q            <= 1'b0;
            dividend_out     <= '0;
            product_full_out <= '0;
            overflow_out     <= 1'b0;
            error_out        <= 1'b0;
            busy_out         <= 1'b0;
            data_valid_out   <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (data_valid_in) begin
                        // Remainder seeds the accumulator so the add comes for free.
                        acc      <= {{WIDTH{1'b0}}, remainder_in};
                        mcand    <= {{WIDTH{1'b0}}, divisor_in};
                        mplier   <= quotient_in;
                        count    <= '0;
                        err_q    <= (remainder_in >= divisor_in);
                        busy_out <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    // Max result is 2^(2W) - 2^W, so acc cannot wrap.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LastIter) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    product_full_out <= acc;
                    dividend_out     <= acc[WIDTH-1:0];
                    overflow_out     <= |acc[2*WIDTH-1:WIDTH];
                    error_out        <= err_q;
                    data_valid_out   <= 1'b1;
                    busy_out         <= 1'b0;
                    state            <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
